sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer. It sits directly upstream of the team's parallel-load register.
- Collects WIDTH serial bits under a start/valid handshake.
- Presents the assembled word on a stable parallel bus.
- Issues a one-cycle load strobe that drives the downstream register's load input.
- Partial words are never visible on the output.

---
 rtl/sipo_deser.sv | 139 +++++++++++++
 tb/tb_sipo_deser.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in/parallel-out deserializer with one-cycle load strobe
// Optional trailing even-parity check when SIPO_PARITY_CHK_EN is defined (adds perr).
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin_valid,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             load,
  output logic             busy
`ifdef SIPO_PARITY_CHK_EN
  ,
  output logic             perr
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SIPO_PARITY_CHK_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] sr_shift;
  logic             last_bit;
`ifdef SIPO_PARITY_CHK_EN
  logic             perr_q, perr_d;
`endif

  // Shift direction decides which end of the word the first serial bit ends up in.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shift = {sr_q[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign sr_shift = {sin, sr_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef SIPO_PARITY_CHK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef SIPO_PARITY_CHK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef SIPO_PARITY_CHK_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (sin_valid) begin
          sr_d = sr_shift;
          if (last_bit) begin
            // Counter parks at WIDTH-1; it is cleared again on the next SHIFT entry.
`ifdef SIPO_PARITY_CHK_EN
            state_d = S_PARITY;
`else
            out_d   = sr_shift;
            state_d = S_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef SIPO_PARITY_CHK_EN
      S_PARITY: begin
        if (sin_valid) begin
          if (((^sr_q) ^ sin) == 1'b0) begin
            out_d   = sr_q;
            state_d = S_DONE;
          end else begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out  = out_q;
  assign load = (state_q == S_DONE);
`ifdef SIPO_PARITY_CHK_EN
  assign busy = (state_q == S_SHIFT) || (state_q == S_PARITY);
  assign perr = perr_q;
`else
  assign busy = (state_q == S_SHIFT);
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - bench for sipo_deser, MSB-first and LSB-first instances side by side
// Honours SIPO_PARITY_CHK_EN when the design is built with it.
module tb_sipo_deser;

`ifdef SIPO_PARITY_CHK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PER = 5 + PAR;

  logic       clk = 1'b0;
  logic       rst, start, sin_valid, sin;
  logic [3:0] out_m, out_l;
  logic       load_m, load_l, busy_m, busy_l;
  logic       perr_m, perr_l;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [3:0] prev_m = '0;
  logic [3:0] prev_l = '0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .sin_valid(sin_valid), .sin(sin),
    .out(out_m), .load(load_m), .busy(busy_m)
`ifdef SIPO_PARITY_CHK_EN
    , .perr(perr_m)
`endif
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .sin_valid(sin_valid), .sin(sin),
    .out(out_l), .load(load_l), .busy(busy_l)
`ifdef SIPO_PARITY_CHK_EN
    , .perr(perr_l)
`endif
  );

`ifndef SIPO_PARITY_CHK_EN
  assign perr_m = 1'b0;
  assign perr_l = 1'b0;
`endif

  typedef struct {
    logic [3:0] seq;        // seq[i] is the i-th serial bit
    int         gap_pos;
    int         gap_len;
    int         start_mode; // 0 low, 1 random, 2 held high
    bit         bad_par;
    bit         chain;
    bit         chk_period;
    logic [3:0] exp_m;
    logic [3:0] exp_l;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag, input bit ld, input bit bz, input bit pe,
                           input logic [3:0] em, input logic [3:0] el);
    check({tag, ".load_m"}, load_m, ld);
    check({tag, ".load_l"}, load_l, ld);
    check({tag, ".busy_m"}, busy_m, bz);
    check({tag, ".busy_l"}, busy_l, bz);
    check({tag, ".perr_m"}, perr_m, pe);
    check({tag, ".perr_l"}, perr_l, pe);
    check({tag, ".out_m"}, out_m, em);
    check({tag, ".out_l"}, out_l, el);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic drive_start(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'($urandom);
    return 1'b0;
  endfunction

  // Reference: bit i of the serial stream has weight 2^(3-i) MSB-first, 2^i LSB-first.
  function automatic logic [3:0] model(input logic [3:0] seq, input bit msb_first);
    int v = 0;
    for (int i = 0; i < 4; i++)
      if (seq[i]) v += msb_first ? (8 >> i) : (1 << i);
    return v[3:0];
  endfunction

  task automatic idle_step();
    start = 1'b0; sin_valid = 1'($urandom); sin = 1'($urandom);
    step();
    check_all("idle", 1'b0, 1'b0, 1'b0, prev_m, prev_l);
  endtask

  task automatic send_word(input logic [3:0] seq, input int gap_pos, input int gap_len,
                           input int mode, input bit bad_par,
                           input logic [3:0] em, input logic [3:0] el, output int load_cyc);
    int s;
    int gaps;
    gaps = 0;
    start = 1'b1; sin_valid = 1'($urandom); sin = 1'($urandom);
    step();
    s = cyc;
    check_all("start", 1'b0, 1'b1, 1'b0, prev_m, prev_l);
    for (int i = 0; i < 4; i++) begin
      if (i == gap_pos) begin
        for (int g = 0; g < gap_len; g++) begin
          sin_valid = 1'b0; sin = 1'($urandom); start = drive_start(mode);
          step();
          gaps++;
          check_all("gap", 1'b0, 1'b1, 1'b0, prev_m, prev_l);
        end
      end
      sin_valid = 1'b1; sin = seq[i]; start = drive_start(mode);
      step();
      if (i < 3) check_all("bit", 1'b0, 1'b1, 1'b0, prev_m, prev_l);
    end
`ifdef SIPO_PARITY_CHK_EN
    check_all("par_wait", 1'b0, 1'b1, 1'b0, prev_m, prev_l);
    sin_valid = 1'b1; sin = (^seq) ^ bad_par; start = drive_start(mode);
    step();
    if (bad_par) begin
      check_all("par_bad", 1'b0, 1'b0, 1'b1, prev_m, prev_l);
    end else begin
      check_all("par_ok", 1'b1, 1'b0, 1'b0, em, el);
      prev_m = em; prev_l = el;
    end
`else
    check_all("done", 1'b1, 1'b0, 1'b0, em, el);
    prev_m = em; prev_l = el;
`endif
    check("latency", cyc - s, 4 + gaps + PAR);
    load_cyc = cyc;
    sin_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    int prev_load, this_load;
    logic [3:0] rs;
    vec_t v;

    //              seq      gpos glen mode bad chain per  exp_m    exp_l
    vecs[0] = '{4'b0101, -1, 0, 0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0101};
    vecs[1] = '{4'b0101,  2, 3, 0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0101};
    vecs[2] = '{4'b0011, -1, 0, 2, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b0011};
    vecs[3] = '{4'b1100, -1, 0, 2, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b1100};
    vecs[4] = '{4'b0001, -1, 0, 1, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0001};
    vecs[5] = '{4'b1101,  1, 2, 1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1101};
    vecs[6] = '{4'b1101, -1, 0, 0, 1'b1, 1'b0, 1'b0, 4'b1011, 4'b1101};

    rst = 1'b1; start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    idle_step();

    prev_load = 0;
    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      send_word(v.seq, v.gap_pos, v.gap_len, v.start_mode, v.bad_par, v.exp_m, v.exp_l, this_load);
      if (v.chk_period) check("b2b_period", this_load - prev_load, PER);
      prev_load = this_load;
      if (!v.chain) idle_step();
    end

    // Reset after two bits discards the partial word and clears out.
    start = 1'b1; step(); start = 1'b0;
    sin_valid = 1'b1; sin = 1'b1; step();
    sin = 1'b0; step();
    rst = 1'b1; sin_valid = 1'b1; sin = 1'b1;
    step();
    rst = 1'b0; sin_valid = 1'b0;
    check_all("rst_mid", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    prev_m = '0; prev_l = '0;
    idle_step();
    send_word(4'b0110, -1, 0, 0, 1'b0, 4'b0110, 4'b0110, this_load);
    idle_step();

    for (int r = 0; r < 40; r++) begin
      rs = 4'($urandom);
      send_word(rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom), model(rs, 1'b1), model(rs, 1'b0), this_load);
      if ($urandom_range(0, 1) == 1) idle_step();
    end
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
